// File: rtl/tinyqv_timecmp_pkg.sv
// Shared constants for the nibble-serial mtime/mtimecmp datapath.
package tinyqv_pkg;

  localparam int          NIBBLE_W       = 4;
  localparam int          WORD_NIBBLES   = 8;
  localparam int          WORD_W         = NIBBLE_W * WORD_NIBBLES;
  localparam int          CNT_W          = 3;
  localparam logic [2:0]  LAST_NIBBLE    = 3'd7;
  localparam logic [31:0] MTIMECMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/tinyqv_timecmp_if.sv
// Nibble-serial timer-compare bus: shared nibble index, mtime stream, CSR access and irq.
interface tinyqv_timecmp_if;
  import tinyqv_pkg::*;

  logic [CNT_W-1:0]    counter;
  logic [NIBBLE_W-1:0] mtime_in;
  logic                set;
  logic [NIBBLE_W-1:0] data_in;
  logic [NIBBLE_W-1:0] data_out;
  logic                irq_en;
  logic                irq;

  modport master (
    output counter, mtime_in, set, data_in, irq_en,
    input  data_out, irq
  );

  modport slave (
    input  counter, mtime_in, set, data_in, irq_en,
    output data_out, irq
  );

endinterface

// File: rtl/tinyqv_timecmp_nibble_sub.sv
// Combinational 4-bit subtract-with-borrow; one step of a nibble-serial compare/subtract chain.
module tinyqv_nibble_sub
  import tinyqv_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                b_in,
  output logic [NIBBLE_W-1:0] diff,
  output logic                b_out
);

  logic [NIBBLE_W:0] full;

  assign full  = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, b_in};
  assign diff  = full[NIBBLE_W-1:0];
  assign b_out = full[NIBBLE_W];

endmodule

// File: rtl/tinyqv_timecmp.sv
// mtimecmp holder: serial unsigned compare of the mtime nibble stream, level timer irq,
// and nibble-serial readback of mtimecmp.
module tinyqv_timecmp
  import tinyqv_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_CMP = MTIMECMP_RESET
) (
  input  logic            clk,
  input  logic            rst,
  tinyqv_timecmp_if.slave bus
);

  logic [WORD_W-1:0]   cmp_q, cmp_d;
  logic                borrow_q, borrow_d;
  logic                dirty_q, dirty_d;
  logic                ge_q, ge_d;

  logic [4:0]          nib_base;
  logic [NIBBLE_W-1:0] cmp_nib;
  logic [NIBBLE_W-1:0] unused_diff;
  logic                b_in;
  logic                b_out;
  logic                last_nib;

  assign nib_base = {bus.counter, 2'b00};
  assign cmp_nib  = cmp_q[nib_base +: NIBBLE_W];
  assign last_nib = (bus.counter == LAST_NIBBLE);
  assign b_in     = (bus.counter == '0) ? 1'b0 : borrow_q;

  tinyqv_nibble_sub u_sub (
    .a     (bus.mtime_in),
    .b     (cmp_nib),
    .b_in  (b_in),
    .diff  (unused_diff),
    .b_out (b_out)
  );

  always_comb begin
    cmp_d    = cmp_q;
    borrow_d = b_out;
    dirty_d  = dirty_q | bus.set;
    ge_d     = ge_q;

    if (bus.set) begin
      cmp_d[nib_base +: NIBBLE_W] = bus.data_in;
    end

    // A sweep that saw any write compared against a half-updated cmp; keep the old result.
    if (last_nib) begin
      dirty_d = 1'b0;
      if (!dirty_q && !bus.set) begin
        ge_d = ~b_out;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q    <= RESET_CMP;
      borrow_q <= 1'b0;
      dirty_q  <= 1'b0;
      ge_q     <= 1'b0;
    end else begin
      cmp_q    <= cmp_d;
      borrow_q <= borrow_d;
      dirty_q  <= dirty_d;
      ge_q     <= ge_d;
    end
  end

  assign bus.data_out = cmp_nib;
  assign bus.irq      = ge_q & bus.irq_en;

endmodule
